// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter bus slave among NUM_REQ byte
// producers. Each granted byte polls the transmitter status word until its
// buffer-empty bit is set, then issues a single byte write. Every bus access is
// followed by at least one idle cycle, and the FSM waits there until the
// slave's registered ready has dropped.
// Optional macro UART_ARB_LINE_LOCK_EN: keep re-granting the same requester
// until it writes 8'h0A, so that lines are not interleaved.
module uart_tx_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter logic [31:0] TX_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 tx_enable,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [3:0]           tx_wstrb,
  output logic [31:0]          tx_wdata,
  output logic [31:0]          tx_addr,
  input  logic [31:0]          tx_rdata
);

  typedef enum logic [1:0] {IDLE, POLL, WRITE, GAP} state_t;
  // Where the FSM goes once the gap after an access is over.
  typedef enum logic [1:0] {AFTER_POLL, AFTER_WRITE, AFTER_IDLE} after_t;

  // The access is abandoned in the cycle the timer would reach TIMEOUT,
  // so tx_valid is high for exactly TIMEOUT cycles without an ack.
  localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT - 1);
  localparam logic [2:0]  GRANT_RESET = 3'(NUM_REQ - 1);

  state_t      state_reg;
  state_t      state_next;
  after_t      after_reg;
  logic [2:0]  grant_reg;
  logic [7:0]  byte_reg;
  logic [15:0] timer_reg;
  logic        err_reg;
  logic        ack_reg;

  logic [7:0]  valid_pad;
  logic [63:0] data_pad;
  logic        arb_found;
  logic [2:0]  arb_idx;
  logic [2:0]  cand;
  logic        lock_hit;
  logic        grant_take;
  logic [2:0]  grant_sel;
  logic        timer_hit;
  logic        unused_rdata;

  // Pad requester vectors to the 8-requester maximum so 3-bit indices work for any NUM_REQ.
  assign valid_pad    = 8'(req_valid);
  assign data_pad     = 64'(req_data);
  assign unused_rdata = &{1'b0, tx_rdata[31:1]};

  // Round-robin search: first valid requester after the last grant, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = grant_reg;
    cand      = grant_reg;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = 3'((int'(grant_reg) + k) % NUM_REQ);
      if (valid_pad[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

`ifdef UART_ARB_LINE_LOCK_EN
  logic lock_reg;

  assign lock_hit = lock_reg && valid_pad[grant_reg];

  // Line lock: set after a non-newline byte is acked; dropped on newline, idle requester or timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!lock_hit) lock_reg <= 1'b0;
        end
        POLL, WRITE: begin
          if (tx_ready) begin
            if (state_reg == WRITE) lock_reg <= (byte_reg != 8'h0A);
          end else if (timer_hit) begin
            lock_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign lock_hit = 1'b0;
`endif

  assign grant_take = lock_hit || arb_found;
  assign grant_sel  = lock_hit ? grant_reg : arb_idx;
  assign timer_hit  = !tx_ready && (timer_reg == TIMER_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; GAP is left only once the slave's registered ready has dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_take) state_next = POLL;
      end
      POLL, WRITE: begin
        if (tx_ready || timer_hit) state_next = GAP;
      end
      GAP: begin
        if (!tx_ready) begin
          case (after_reg)
            AFTER_POLL:  state_next = POLL;
            AFTER_WRITE: state_next = WRITE;
            default:     state_next = IDLE;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: grant/byte latch, status sampling, access timer, ack pulse and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_reg <= GRANT_RESET;
      byte_reg  <= 8'h00;
      timer_reg <= 16'h0000;
      after_reg <= AFTER_IDLE;
      err_reg   <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          timer_reg <= 16'h0000;
          if (grant_take) begin
            grant_reg <= grant_sel;
            byte_reg  <= data_pad[{grant_sel, 3'b000} +: 8];
          end
        end
        POLL, WRITE: begin
          if (tx_ready) begin
            if (state_reg == WRITE) begin
              after_reg <= AFTER_IDLE;
              ack_reg   <= 1'b1;
            end else begin
              after_reg <= tx_rdata[0] ? AFTER_WRITE : AFTER_POLL;
            end
          end else if (timer_hit) begin
            after_reg <= AFTER_IDLE;
            err_reg   <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        GAP: begin
          timer_reg <= 16'h0000;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs decoded from the current state.
  always_comb begin
    tx_valid = 1'b0;
    tx_wstrb = 4'b0000;
    tx_wdata = 32'h0000_0000;
    case (state_reg)
      POLL: begin
        tx_valid = 1'b1;
      end
      WRITE: begin
        tx_valid = 1'b1;
        tx_wstrb = 4'b0001;
        tx_wdata = {24'h00_0000, byte_reg};
      end
      default: ;
    endcase
    tx_enable = tx_valid;
    busy      = (state_reg != IDLE);
  end

  assign tx_addr     = TX_ADDR;
  assign grant_id    = grant_reg;
  assign err_timeout = err_reg;

  // One-hot ack towards the granted requester only.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = ack_reg && (grant_reg == 3'(gi));
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a registered-ready transmitter
// model, producer byte queues and an ack scoreboard.
module tb_uart_tx_arbiter;
  localparam int          NREQ = 4;
  localparam logic [31:0] ADDR = 32'h1000_0040;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [8*NREQ-1:0]  req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic [2:0]         grant_id;
  logic               busy;
  logic               err_timeout;
  logic               tx_enable;
  logic               tx_valid;
  logic               tx_ready;
  logic [3:0]         tx_wstrb;
  logic [31:0]        tx_wdata;
  logic [31:0]        tx_addr;
  logic [31:0]        tx_rdata;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .TX_ADDR(ADDR), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout),
    .tx_enable(tx_enable), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_wstrb(tx_wstrb), .tx_wdata(tx_wdata), .tx_addr(tx_addr),
    .tx_rdata(tx_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] prod_q[NREQ][$];
  int         errors = 0;
  int         checks = 0;
  int         acks = 0;
  int         rises = 0;
  logic       prev_valid = 1'b0;

  // Slave configuration (set by the stimulus) and slave-owned state.
  logic        slave_mute = 1'b0;
  int          stale_extra = 0;
  int          empty_after = 0;
  int          hold_cnt = 0;
  logic        in_hold = 1'b0;
  int          read_total = 0;
  int          write_total = 0;
  int          stale_viol = 0;
  logic [31:0] last_wdata = 32'h0;

  // Transmitter model: ready registered one cycle after valid, optionally held
  // high for stale_extra extra cycles; buffer reports empty once read_total >= empty_after.
  always @(posedge clk) begin
    if (reset) begin
      tx_ready <= 1'b0;
      tx_rdata <= 32'h0;
      hold_cnt <= 0;
      in_hold  <= 1'b0;
    end else begin
      if (tx_valid && in_hold) stale_viol <= stale_viol + 1;
      if (hold_cnt > 0) begin
        tx_ready <= 1'b1;
        in_hold  <= 1'b1;
        hold_cnt <= hold_cnt - 1;
      end else if (tx_valid && !tx_ready && !slave_mute) begin
        tx_ready <= 1'b1;
        in_hold  <= 1'b0;
        hold_cnt <= stale_extra;
        if (tx_wstrb == 4'b0000) begin
          tx_rdata   <= {31'h0, (read_total >= empty_after)};
          read_total <= read_total + 1;
        end else begin
          tx_rdata    <= 32'h0;
          write_total <= write_total + 1;
          last_wdata  <= tx_wdata;
        end
      end else begin
        tx_ready <= 1'b0;
        in_hold  <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic handle_ack();
    exp_t       e;
    int         id;
    logic [7:0] tmp;
    acks++;
    if (sb.size() == 0) begin
      check("unexpected_ack", 32'(req_ready), 32'h0);
    end else begin
      e  = sb.pop_front();
      id = int'(e.id);
      $display("ack req=%0d data=0x%02h wdata=0x%0h t=%0t", id, e.data, last_wdata, $time);
      check("ack_id", 32'(req_ready), 32'(1) << id);
      check("ack_data", last_wdata, {24'h0, e.data});
      if (prod_q[id].size() > 0) tmp = prod_q[id].pop_front();
      if (prod_q[id].size() > 0) req_data[8*id +: 8] = prod_q[id][0];
      else req_valid[id] = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (tx_valid === 1'b1 && prev_valid !== 1'b1) rises++;
    prev_valid = tx_valid;
    if (req_ready !== '0) handle_ack();
  endtask

  task automatic offer(input int id, input logic [7:0] data);
    prod_q[id].push_back(data);
    if (req_valid[id] !== 1'b1) begin
      req_data[8*id +: 8] = data;
      req_valid[id] = 1'b1;
    end
  endtask

  task automatic expect_ack(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = 3'(id);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy !== 1'b0 && n < 20);
    check({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int n, hi, a0, r0, w0, v0, nexp;

    // Reset values
    tick();
    tick();
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_enable", 32'(tx_enable), 32'h0);
    check("rst_tx_wstrb", 32'(tx_wstrb), 32'h0);
    check("rst_tx_wdata", tx_wdata, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'(NREQ - 1));
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err_timeout", 32'(err_timeout), 32'h0);
    check("tx_addr", tx_addr, ADDR);
    reset = 1'b0;
    tick();
    tick();

    // Single requester 0 sends 8'h41 to an empty transmitter: 7-cycle byte, ack visible in tick 6
    r0 = read_total; w0 = write_total; v0 = rises; a0 = acks; n = 0;
    offer(0, 8'h41);
    expect_ack(0, 8'h41);
    do begin
      tick();
      n++;
    end while (acks == a0 && n < 30);
    check("single_latency", 32'(n), 32'd6);
    wait_idle("single");
    check("single_reads", 32'(read_total - r0), 32'd1);
    check("single_writes", 32'(write_total - w0), 32'd1);
    check("single_rises", 32'(rises - v0), 32'd2);
    check("single_grant", 32'(grant_id), 32'd0);

    // Buffer full for three polls: four separated reads, then one write
    r0 = read_total; w0 = write_total; v0 = rises;
    empty_after = read_total + 3;
    offer(2, 8'h5A);
    expect_ack(2, 8'h5A);
    wait_drain("poll", 100);
    wait_idle("poll");
    check("poll_reads", 32'(read_total - r0), 32'd4);
    check("poll_writes", 32'(write_total - w0), 32'd1);
    check("poll_rises", 32'(rises - v0), 32'd5);
    check("poll_grant", 32'(grant_id), 32'd2);

    // Reset while the write is on the bus: no ack, bus released, grant back to NUM_REQ-1
    w0 = write_total; n = 0;
    offer(1, 8'h77);
    do begin
      tick();
      n++;
    end while (!(tx_valid === 1'b1 && tx_wstrb === 4'b0001) && n < 30);
    check("reached_write", 32'(tx_wstrb), 32'h1);
    reset = 1'b1;
    req_valid[1] = 1'b0;
    prod_q[1].delete();
    tick();
    check("midrst_tx_valid", 32'(tx_valid), 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'h0);
    check("midrst_grant_id", 32'(grant_id), 32'(NREQ - 1));
    check("midrst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (3) tick();
    check("midrst_no_write", 32'(write_total - w0), 32'd0);

    // All four requesters valid continuously
    w0 = write_total;
`ifdef UART_ARB_LINE_LOCK_EN
    offer(0, 8'h30); offer(0, 8'h0A);
    offer(1, 8'h61); offer(1, 8'h62); offer(1, 8'h0A);
    offer(2, 8'h32); offer(2, 8'h0A);
    offer(3, 8'h34); offer(3, 8'h0A);
    expect_ack(0, 8'h30); expect_ack(0, 8'h0A);
    expect_ack(1, 8'h61); expect_ack(1, 8'h62); expect_ack(1, 8'h0A);
    expect_ack(2, 8'h32); expect_ack(2, 8'h0A);
    expect_ack(3, 8'h34); expect_ack(3, 8'h0A);
`else
    offer(0, 8'h30); offer(0, 8'h31);
    offer(1, 8'h61); offer(1, 8'h62);
    offer(2, 8'h32); offer(2, 8'h33);
    offer(3, 8'h34); offer(3, 8'h35);
    expect_ack(0, 8'h30); expect_ack(1, 8'h61); expect_ack(2, 8'h32); expect_ack(3, 8'h34);
    expect_ack(0, 8'h31); expect_ack(1, 8'h62); expect_ack(2, 8'h33); expect_ack(3, 8'h35);
`endif
    nexp = sb.size();
    wait_drain("rr", 300);
    wait_idle("rr");
    check("rr_writes", 32'(write_total - w0), 32'(nexp));

    // Transmitter never answers: tx_valid drops after 255 cycles, sticky error, no ack
    slave_mute = 1'b1; a0 = acks; n = 0;
    offer(3, 8'h7E);
    do begin
      tick();
      n++;
    end while (tx_valid !== 1'b1 && n < 20);
    hi = 0;
    while (tx_valid === 1'b1 && hi < 400) begin
      hi++;
      tick();
    end
    check("timeout_cycles", 32'(hi), 32'd255);
    check("timeout_err", 32'(err_timeout), 32'h1);
    check("timeout_grant", 32'(grant_id), 32'd3);
    check("timeout_busy", 32'(busy), 32'h1);
    check("timeout_no_ack", 32'(acks - a0), 32'd0);
    // The timed-out requester is retried after the others
    offer(0, 8'h55);
    slave_mute = 1'b0;
    expect_ack(0, 8'h55);
    expect_ack(3, 8'h7E);
    wait_drain("retry", 300);
    wait_idle("retry");
    check("err_sticky", 32'(err_timeout), 32'h1);

    // Ready held two extra cycles after each ack: FSM waits in GAP, single ack
    stale_extra = 2;
    r0 = read_total; w0 = write_total; a0 = acks; n = 0;
    offer(1, 8'h99);
    expect_ack(1, 8'h99);
    do begin
      tick();
      n++;
    end while (acks == a0 && n < 30);
    check("stale_latency", 32'(n), 32'd8);
    wait_idle("stale");
    repeat (3) tick();
    check("stale_acks", 32'(acks - a0), 32'd1);
    check("stale_reads", 32'(read_total - r0), 32'd1);
    check("stale_writes", 32'(write_total - w0), 32'd1);
    check("stale_viol", 32'(stale_viol), 32'd0);
    stale_extra = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
